mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register.
- Takes the address (aluresultM), store data and load/store type from EX/MEM and runs a request/ready handshake on the data-memory bus.
- Generates byte enables and aligned store data; aligns and sign/zero-extends load data into readDataM for MEM/WB.
- Stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, width of dmem_addr.
- TIMEOUT, 16, maximum BUSY cycles waiting for dmem_ready (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  input  1  single pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- memreadM  input  1  load in MEM stage.
- memwriteM  input  1  store in MEM stage.
- loadsrcM  input  3  load type: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu; others treated as lw.
- storesrcM  input  2  store type: 00 sw, 01 sb, 10 sh, 11 treated as sw.
- aluresultM  input  32  effective address.
- writedataM  input  32  store data (rs2).
- dmem_rdata  input  32  memory read data, valid with dmem_ready.
- dmem_ready  input  1  memory completes the current request.
- dmem_req  output  1  request valid, registered.
- dmem_we  output  1  1 = write, registered.
- dmem_addr  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}, registered.
- dmem_wdata  output  32  lane-replicated store data, registered.
- dmem_be  output  4  byte enables, registered.
- readDataM  output  32  extended load result to MEM/WB, registered.
- stallM  output  1  freeze IF..EX/MEM, combinational.
- misalignM  output  1  misaligned access flag, combinational.
- buserrM  output  1  bus timeout flag, registered.

Behaviour:
- Reset (async, any state): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, readDataM=0, buserrM=0, timeout counter=0. A request in flight is dropped.
- pending = (memreadM | memwriteM) & ~misalignM. If both memreadM and memwriteM are high, memwriteM wins (store).
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - misalignM=1 combinationally; no request issued; stallM=0; readDataM unchanged.
- FSM IDLE:
  - If pending: latch dmem_addr, dmem_we, dmem_wdata and dmem_be; set dmem_req=1; clear counter; go to BUSY.
  - stallM=1 in this cycle.
- FSM BUSY:
  - dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_be held stable. stallM=1.
  - On dmem_ready=1: dmem_req<=0. For a load, readDataM<=extend(dmem_rdata). Go to DONE.
- FSM DONE:
  - stallM=0 for exactly one cycle, so the pipeline advances and MEM/WB captures readDataM.
  - Next state IDLE.
- Every access costs at least 3 cycles (IDLE, BUSY×n with n≥1, DONE).
- dmem_ready is ignored outside BUSY.
- Store lanes:
  - sb: wdata={4{wd[7:0]}}, be=4'b0001<<addr[1:0].
  - sh: wdata={2{wd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - sw: wdata=wd, be=1111.
- Load extract:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - Address bits used are those latched in IDLE.
- Stores never update readDataM. readDataM holds its value until the next load completes.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - Counter increments each BUSY cycle without dmem_ready.
  - When it reaches TIMEOUT, dmem_req<=0, readDataM<=0, go to DONE, and buserrM=1 for the DONE cycle only.
  - If dmem_ready arrives on the timeout cycle, ready wins and buserrM stays 0.
- Not defined: no counter; BUSY waits indefinitely; buserrM tied 0.

Test Plan:
- lw at 0x100, ready after 2 BUSY cycles, rdata=0xDEADBEEF -> dmem_req high 2 cycles, dmem_addr=0x100, stallM high 3 cycles then low 1, readDataM=0xDEADBEEF in DONE.
- lb at 0x103, rdata=0x80AABBCC -> readDataM=0xFFFFFF80. lbu at the same address -> 0x00000080. lhu at 0x102, rdata=0x8001xxxx -> 0x00008001.
- sh at 0x206, wd=0x1234ABCD -> dmem_we=1, dmem_addr=0x204, dmem_be=1100, dmem_wdata=0xABCDABCD. readDataM unchanged.
- lw at 0x101 -> misalignM=1, dmem_req stays 0, stallM=0.
- rst asserted mid-BUSY -> dmem_req=0 and state IDLE immediately, without waiting for a clock edge. After release, a fresh lw completes normally.
- With DMEM_TIMEOUT_EN, TIMEOUT=4, ready never asserted -> dmem_req drops after 4 BUSY cycles, buserrM=1 for one cycle, readDataM=0, stallM releases.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Purpose:
//   Memory stage of the 5-stage pipeline, between EX/MEM and MEM/WB.
//   It turns a load or store held in EX/MEM into one request/ready
//   transaction on the data-memory bus. It builds the byte enables and the
//   lane-replicated store data. It aligns and sign/zero-extends load data
//   into readDataM, and it stalls the front of the pipeline while an access
//   is outstanding.
//
// Optional feature:
//   `DMEM_TIMEOUT_EN - when defined, a BUSY wait is bounded to TIMEOUT
//   cycles. On expiry the request is dropped, readDataM is cleared and
//   buserrM pulses during DONE. When undefined, BUSY waits indefinitely and
//   buserrM is tied to 0.
//
// Handshake:
//   dmem_req is raised on the clock edge that leaves IDLE. From then until
//   the transaction completes, dmem_req, dmem_we, dmem_addr, dmem_wdata and
//   dmem_be stay constant. The memory completes the transaction by holding
//   dmem_ready high for one rising edge while the stage is in BUSY; on a
//   load, dmem_rdata must be valid in that same cycle. The stage ignores
//   dmem_ready and dmem_rdata whenever it is not in BUSY.
//
// Ports:
//   clk, rst                 pipeline clock (rising edge); async active-high reset
//   memreadM, memwriteM      load / store present in MEM (the store wins if both are set)
//   loadsrcM                 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu, other = lw
//   storesrcM                00 sw, 01 sb, 10 sh, 11 = sw
//   aluresultM               effective byte address
//   writedataM               store data (rs2)
//   dmem_rdata, dmem_ready   memory read data / completion strobe
//   dmem_req, dmem_we        registered request valid / write flag
//   dmem_addr                registered word-aligned address
//   dmem_wdata, dmem_be      registered store data / byte enables
//   readDataM                registered extended load result to MEM/WB
//   stallM                   combinational freeze of IF..EX/MEM
//   misalignM                combinational misaligned-access flag
//   buserrM                  registered bus-timeout flag (high for the DONE cycle)
//   dbg_state                current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [2:0]        loadsrcM,
    input  logic [1:0]        storesrcM,
    input  logic [31:0]       aluresultM,
    input  logic [31:0]       writedataM,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    output logic [31:0]       readDataM,
    output logic              stallM,
    output logic              misalignM,
    output logic              buserrM,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic                dmem_req_q,   dmem_req_d;
    logic                dmem_we_q,    dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q,  dmem_addr_d;
    logic [31:0]         dmem_wdata_q, dmem_wdata_d;
    logic [3:0]          dmem_be_q,    dmem_be_d;
    logic [31:0]         read_data_q,  read_data_d;
    // The byte lane and the load type are captured in IDLE. The extraction
    // in BUSY therefore does not depend on what EX/MEM presents later.
    logic [1:0]          addr_lo_q,    addr_lo_d;
    logic [2:0]          ld_type_q,    ld_type_d;

    // -----------------------------------------------------------------------
    // Access decode (combinational, from EX/MEM)
    // -----------------------------------------------------------------------
    size_t       acc_size;
    logic        access;
    logic        misalign_raw;
    logic        pending;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    always_comb begin
        acc_size = SZ_WORD;
        if (memwriteM) begin
            case (storesrcM)
                2'b01:   acc_size = SZ_BYTE;
                2'b10:   acc_size = SZ_HALF;
                default: acc_size = SZ_WORD;
            endcase
        end else begin
            case (loadsrcM)
                3'b001, 3'b011: acc_size = SZ_BYTE;
                3'b010, 3'b100: acc_size = SZ_HALF;
                default:        acc_size = SZ_WORD;
            endcase
        end
    end

    always_comb begin
        misalign_raw = 1'b0;
        case (acc_size)
            SZ_HALF: misalign_raw = aluresultM[0];
            SZ_WORD: misalign_raw = (aluresultM[1:0] != 2'b00);
            default: misalign_raw = 1'b0;
        endcase
    end

    assign access    = memreadM | memwriteM;
    assign misalignM = access & misalign_raw;
    assign pending   = access & ~misalign_raw;

    // Store lane replication and byte enables. A load gets the enables of
    // its access width as well, which keeps dmem_be meaningful on reads.
    always_comb begin
        st_wdata = writedataM;
        st_be    = 4'b1111;
        case (acc_size)
            SZ_BYTE: begin
                st_wdata = {4{writedataM[7:0]}};
                st_be    = 4'b0001 << aluresultM[1:0];
            end
            SZ_HALF: begin
                st_wdata = {2{writedataM[15:0]}};
                st_be    = aluresultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = writedataM;
                st_be    = 4'b1111;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Load alignment and extension
    // -----------------------------------------------------------------------
    function automatic logic [31:0] load_extend(
        input logic [2:0]  ld_type,
        input logic [1:0]  lane,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (ld_type)
            3'b001:  return {{24{b[7]}}, b};
            3'b010:  return {{16{h[15]}}, h};
            3'b011:  return {24'h000000, b};
            3'b100:  return {16'h0000, h};
            default: return rdata;
        endcase
    endfunction

    logic [31:0] load_value;
    assign load_value = load_extend(ld_type_q, addr_lo_q, dmem_rdata);

    // -----------------------------------------------------------------------
    // Optional bus timeout
    // -----------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // The last BUSY cycle is counter value TIMEOUT-1, so the request stays
    // up for exactly TIMEOUT BUSY cycles before it is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             buserr_q, buserr_d;

    assign buserrM = buserr_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign buserrM        = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        read_data_d  = read_data_q;
        addr_lo_d    = addr_lo_q;
        ld_type_d    = ld_type_q;
        stallM       = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        buserr_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    stallM       = 1'b1;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = memwriteM;
                    dmem_addr_d  = {aluresultM[ADDR_W-1:2], 2'b00};
                    dmem_wdata_d = st_wdata;
                    dmem_be_d    = st_be;
                    addr_lo_d    = aluresultM[1:0];
                    ld_type_d    = loadsrcM;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    state_d      = S_BUSY;
                end
            end

            S_BUSY: begin
                stallM = 1'b1;
                if (dmem_ready) begin
                    dmem_req_d = 1'b0;
                    if (!dmem_we_q) begin
                        read_data_d = load_value;
                    end
                    state_d = S_DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    dmem_req_d  = 1'b0;
                    read_data_d = 32'h0000_0000;
                    buserr_d    = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            // The pipeline is released for one cycle so that MEM/WB captures
            // readDataM and the next instruction moves into MEM.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d    = S_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'h0000_0000;
            dmem_be_q    <= 4'b0000;
            read_data_q  <= 32'h0000_0000;
            addr_lo_q    <= 2'b00;
            ld_type_q    <= 3'b000;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            read_data_q  <= read_data_d;
            addr_lo_q    <= addr_lo_d;
            ld_type_q    <= ld_type_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
        end
    end
`endif

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_be    = dmem_be_q;
    assign readDataM  = read_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [2:0]  loadsrcM;
  logic [1:0]  storesrcM;
  logic [31:0] aluresultM, writedataM, dmem_rdata;
  logic        dmem_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, readDataM;
  logic [3:0]  dmem_be;
  logic        stallM, misalignM, buserrM;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM),
    .loadsrcM(loadsrcM), .storesrcM(storesrcM),
    .aluresultM(aluresultM), .writedataM(writedataM),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .readDataM(readDataM),
    .stallM(stallM), .misalignM(misalignM), .buserrM(buserrM),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Derived from the access rules: size in bytes, alignment by modulo,
  // lane replication by multiplication, extraction by shifting.
  task automatic model_access(
    input  logic rd, input logic wr, input logic [2:0] ls, input logic [1:0] ss,
    input  logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
    input  logic [31:0] prev,
    output logic mis, output logic [3:0] be, output logic [31:0] wdata,
    output logic [31:0] rdv);
    int size;
    int lane;
    logic [31:0] v;
    if (wr) size = (ss == 2'd1) ? 1 : (ss == 2'd2) ? 2 : 4;
    else    size = (ls == 3'd1 || ls == 3'd3) ? 1 : (ls == 3'd2 || ls == 3'd4) ? 2 : 4;
    lane  = int'(a % 4);
    mis   = (rd || wr) && ((a % size) != 0);
    be    = 4'hF;
    wdata = wd;
    rdv   = prev;
    if (wr) begin
      if (size == 1) begin
        be    = 4'(1 << lane);
        wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (size == 2) begin
        be    = (lane >= 2) ? 4'hC : 4'h3;
        wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end
    end else if (rd && !mis) begin
      v = rdata >> (8 * lane);
      if (size == 1) begin
        v = v & 32'hFF;
        if (ls == 3'd1 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (ls == 3'd2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      rdv = v;
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic apply_vec(
    input logic rd, input logic wr, input logic [2:0] ls, input logic [1:0] ss,
    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata, input int nb,
    input logic exp_mis, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
    input logic [31:0] exp_rd);
    logic [31:0] got_exp;
    memreadM   = rd;
    memwriteM  = wr;
    loadsrcM   = ls;
    storesrcM  = ss;
    aluresultM = a;
    writedataM = wd;
    exp_q.push_back(exp_rd);
    #1;
    check("misalignM", 32'(misalignM), 32'(exp_mis));
    if (exp_mis || (!rd && !wr)) begin
      check("stall_noacc", 32'(stallM), 32'(0));
      @(posedge clk); #1;
      check("req_noacc", 32'(dmem_req), 32'(0));
      got_exp = exp_q.pop_front();
      check("rd_noacc", readDataM, got_exp);
      memreadM  = 1'b0;
      memwriteM = 1'b0;
      return;
    end
    check("stall_idle", 32'(stallM), 32'(1));
    check("req_idle", 32'(dmem_req), 32'(0));
    @(posedge clk); #1;
    check("dmem_we", 32'(dmem_we), 32'(wr));
    check("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
    if (wr) begin
      check("dmem_be", 32'(dmem_be), 32'(exp_be));
      check("dmem_wdata", dmem_wdata, exp_wdata);
    end
    for (int i = 0; i < nb; i++) begin
      dmem_ready = (i == nb - 1);
      dmem_rdata = (i == nb - 1) ? rdata : $urandom;
      #1;
      check("req_busy", 32'(dmem_req), 32'(1));
      check("stall_busy", 32'(stallM), 32'(1));
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
    got_exp = exp_q.pop_front();
    check("stall_done", 32'(stallM), 32'(0));
    check("req_done", 32'(dmem_req), 32'(0));
    check("readDataM", readDataM, got_exp);
    check("buserr_done", 32'(buserrM), 32'(0));
    // ready and data outside BUSY must be ignored
    dmem_ready = 1'b1;
    dmem_rdata = $urandom;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    check("rd_hold", readDataM, got_exp);
    check("req_after", 32'(dmem_req), 32'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ls;
    logic [1:0]  ss;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          nb;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdv;
  } vec_t;

  vec_t tbl[18];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic        m_mis;
    logic [3:0]  m_be;
    logic [31:0] m_wdata, m_rd, r_addr, r_wd, r_rdata;
    logic [2:0]  r_ls;
    logic [1:0]  r_ss;
    logic        r_rd, r_wr;
    int          sel, r_nb, cnt;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 3'd1, 2'd0, 32'h103, 32'h0, 32'h80AABBCC, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 3'd3, 2'd0, 32'h103, 32'h0, 32'h80AABBCC, 3, 1'b0, 4'hF, 32'h0, 32'h00000080};
    tbl[3]  = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h102, 32'h0, 32'h80011234, 1, 1'b0, 4'hF, 32'h0, 32'h00008001};
    tbl[4]  = '{1'b0, 1'b1, 3'd0, 2'd2, 32'h206, 32'h1234ABCD, 32'h0, 2, 1'b0, 4'hC, 32'hABCDABCD, 32'h00008001};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h101, 32'h0, 32'h0, 1, 1'b1, 4'hF, 32'h0, 32'h00008001};
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 2'd1, 32'h001, 32'h000000A5, 32'h0, 1, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h00008001};
    tbl[7]  = '{1'b1, 1'b0, 3'd2, 2'd0, 32'h000, 32'h0, 32'h1234F00F, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFF00F};
    tbl[8]  = '{1'b0, 1'b1, 3'd0, 2'd0, 32'h010, 32'hCAFEF00D, 32'h0, 1, 1'b0, 4'hF, 32'hCAFEF00D, 32'hFFFFF00F};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 2'd2, 32'h003, 32'h0, 32'h0, 1, 1'b1, 4'hF, 32'h0, 32'hFFFFF00F};
    tbl[10] = '{1'b1, 1'b0, 3'd2, 2'd0, 32'h001, 32'h0, 32'h0, 1, 1'b1, 4'hF, 32'h0, 32'hFFFFF00F};
    tbl[11] = '{1'b1, 1'b1, 3'd0, 2'd1, 32'h003, 32'h0000005A, 32'h0, 2, 1'b0, 4'h8, 32'h5A5A5A5A, 32'hFFFFF00F};
    tbl[12] = '{1'b1, 1'b0, 3'd7, 2'd0, 32'h008, 32'h0, 32'h11223344, 1, 1'b0, 4'hF, 32'h0, 32'h11223344};
    tbl[13] = '{1'b0, 1'b1, 3'd0, 2'd3, 32'h002, 32'h0, 32'h0, 1, 1'b1, 4'hF, 32'h0, 32'h11223344};
    tbl[14] = '{1'b1, 1'b0, 3'd2, 2'd0, 32'h002, 32'h0, 32'h7FFF0000, 3, 1'b0, 4'hF, 32'h0, 32'h00007FFF};
    tbl[15] = '{1'b1, 1'b0, 3'd1, 2'd0, 32'h001, 32'h0, 32'h0000FF00, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFF};
    tbl[16] = '{1'b0, 1'b0, 3'd0, 2'd0, 32'h004, 32'h0, 32'h0, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFF};
    tbl[17] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h000, 32'h0, 32'h00008000, 2, 1'b0, 4'hF, 32'h0, 32'h00008000};

    // reset
    rst = 1'b1;
    memreadM = 1'b0; memwriteM = 1'b0; loadsrcM = 3'd0; storesrcM = 2'd0;
    aluresultM = 32'h0; writedataM = 32'h0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'(0));
    check("rst_we", 32'(dmem_we), 32'(0));
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_be", 32'(dmem_be), 32'(0));
    check("rst_rd", readDataM, 32'h0);
    check("rst_buserr", 32'(buserrM), 32'(0));
    check("rst_stall", 32'(stallM), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // table
    for (int i = 0; i < 18; i++) begin
      apply_vec(tbl[i].rd, tbl[i].wr, tbl[i].ls, tbl[i].ss, tbl[i].addr, tbl[i].wd,
                tbl[i].rdata, tbl[i].nb, tbl[i].mis, tbl[i].be, tbl[i].wdata, tbl[i].rdv);
    end
    model_rd = tbl[17].rdv;

    // reset in the middle of BUSY acts without a clock edge
    memreadM = 1'b1; loadsrcM = 3'd0; aluresultM = 32'h20;
    @(posedge clk); #1;
    check("mid_req_before", 32'(dmem_req), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_req_after", 32'(dmem_req), 32'(0));
    check("mid_state", 32'(dbg_state), 32'(0));
    check("mid_rd", readDataM, 32'h0);
    memreadM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_rd = 32'h0;
    apply_vec(1'b1, 1'b0, 3'd0, 2'd0, 32'h24, 32'h0, 32'h0BADF00D, 2, 1'b0, 4'hF, 32'h0, 32'h0BADF00D);
    model_rd = 32'h0BADF00D;

`ifdef DMEM_TIMEOUT_EN
    // no ready at all: request abandoned after 4 BUSY cycles
    memreadM = 1'b1; loadsrcM = 3'd0; aluresultM = 32'h40;
    @(posedge clk); #1;
    cnt = 0;
    while (dmem_req && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("to_busy_cycles", 32'(cnt), 32'(4));
    check("to_buserr", 32'(buserrM), 32'(1));
    check("to_stall", 32'(stallM), 32'(0));
    check("to_rd", readDataM, 32'h0);
    memreadM = 1'b0;
    @(posedge clk); #1;
    check("to_buserr_clr", 32'(buserrM), 32'(0));
    model_rd = 32'h0;
    // ready on the final allowed cycle wins over the timeout
    apply_vec(1'b1, 1'b0, 3'd0, 2'd0, 32'h44, 32'h0, 32'h13579BDF, 4, 1'b0, 4'hF, 32'h0, 32'h13579BDF);
    model_rd = 32'h13579BDF;
`else
    // a long wait never gives up
    apply_vec(1'b1, 1'b0, 3'd0, 2'd0, 32'h44, 32'h0, 32'h13579BDF, 20, 1'b0, 4'hF, 32'h0, 32'h13579BDF);
    model_rd = 32'h13579BDF;
    check("no_buserr", 32'(buserrM), 32'(0));
`endif

    // randomized against the model
    for (int k = 0; k < 200; k++) begin
      sel     = $urandom_range(0, 7);
      r_rd    = (sel == 1 || sel >= 3);
      r_wr    = (sel == 2 || sel == 3 || sel == 6);
      r_ls    = 3'($urandom_range(0, 7));
      r_ss    = 2'($urandom_range(0, 3));
      r_addr  = $urandom & 32'h0000_0FFF;
      r_wd    = $urandom;
      r_rdata = $urandom;
      r_nb    = $urandom_range(1, 4);
      model_access(r_rd, r_wr, r_ls, r_ss, r_addr, r_wd, r_rdata, model_rd,
                   m_mis, m_be, m_wdata, m_rd);
      apply_vec(r_rd, r_wr, r_ls, r_ss, r_addr, r_wd, r_rdata, r_nb, m_mis, m_be, m_wdata, m_rd);
      model_rd = m_rd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
